mem_stall_ctrl: RTL and testbench

//  Multi-cycle request controller between the pipeline MEM stage and the single-cycle 16-bit word memory.

---
 rtl/mem_ctrl_pkg.sv | 12 +
 rtl/mem_wait_counter.sv | 18 +
 rtl/mem_stall_ctrl.sv | 79 +++++++
 tb/tb_mem_stall_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and counter sizing for the memory stall controller
package mem_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_DUMP   = 3'd4
  } state_t;
  localparam int LAT_CNT_W   = 4;
  localparam int MAX_LATENCY = 15;
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter that stops at zero and flags it
module mem_wait_counter
  import mem_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 dec,
  input  logic [LAT_CNT_W-1:0] load_val,
  output logic                 zero
);
  logic [LAT_CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: holds the MEM stage for LATENCY cycles, then performs one access to a single-cycle word memory
module mem_stall_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int LATENCY     = 3,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_dump,
  output logic        stall,
  output logic        done,
  output logic [15:0] rdata,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic        mem_createdump,
  input  logic [15:0] mem_data_out
);
  localparam int LAT = LATENCY > MAX_LATENCY ? MAX_LATENCY : LATENCY;
  state_t state, nxt;
  logic [15:0] addr_q, wdata_q;
  logic wr_q, err_q, cnt_zero, idle_like, aligned, accept, reject, dump_go;
  assign idle_like = state == ST_IDLE || state == ST_DONE;
  assign aligned   = !ALIGN_CHECK || !req_addr[0];
  assign accept    = idle_like && req_valid && aligned;
  assign reject    = idle_like && req_valid && !aligned;
  assign dump_go   = idle_like && !req_valid && req_dump;
  mem_wait_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .dec      (state == ST_WAIT),
    .load_val (LAT_CNT_W'(LAT - 1)),
    .zero     (cnt_zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= nxt;
      err_q <= reject;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wr_q    <= req_wr;
      end
      if (state == ST_ACCESS && !wr_q) rdata <= mem_data_out;
    end
  // stall is gated by rst_n so the combinational acceptance path also reads 0 during reset
  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE, ST_DONE: nxt = accept ? (LAT > 0 ? ST_WAIT : ST_ACCESS) : dump_go ? ST_DUMP : ST_IDLE;
      ST_WAIT:          nxt = cnt_zero ? ST_ACCESS : ST_WAIT;
      ST_ACCESS:        nxt = ST_DONE;
      default:          nxt = ST_IDLE;
    endcase
    stall          = rst_n && (accept || dump_go || state == ST_WAIT || state == ST_ACCESS || state == ST_DUMP);
    done           = state == ST_DONE;
    mem_enable     = state == ST_ACCESS;
    mem_wr         = state == ST_ACCESS && wr_q;
    mem_createdump = state == ST_DUMP;
  end
  assign err         = err_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
endmodule

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: directed scoreboard bench for mem_stall_ctrl (LATENCY=3 main instance, LATENCY=0 side instance)
module tb_mem_stall_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rv, rw, rd;
  logic [15:0] ra, rwd;
  logic stall_a, done_a, err_a, en_a, mwr_a, cd_a;
  logic [15:0] rdata_a, maddr_a, mdin_a, mdo_a;
  logic rv_b, rw_b, rd_b;
  logic [15:0] ra_b, rwd_b;
  logic stall_b, done_b, err_b, en_b, mwr_b, cd_b;
  logic [15:0] rdata_b, maddr_b, mdin_b, mdo_b;
  logic bd_we;
  logic [7:0] bd_addr_a, bd_addr_b;
  logic [15:0] bd_data_a, bd_data_b;
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  always @(posedge clk) begin
    if (bd_we) begin
      mem_a[bd_addr_a] <= bd_data_a;
      mem_b[bd_addr_b] <= bd_data_b;
    end else begin
      if (en_a && mwr_a) mem_a[maddr_a[7:0]] <= mdin_a;
      if (en_b && mwr_b) mem_b[maddr_b[7:0]] <= mdin_b;
    end
  end
  assign mdo_a = mem_a[maddr_a[7:0]];
  assign mdo_b = mem_b[maddr_b[7:0]];

  mem_stall_ctrl #(.LATENCY(3), .ALIGN_CHECK(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_wr(rw), .req_addr(ra), .req_wdata(rwd),
    .req_dump(rd), .stall(stall_a), .done(done_a), .rdata(rdata_a), .err(err_a),
    .mem_addr(maddr_a), .mem_data_in(mdin_a), .mem_enable(en_a), .mem_wr(mwr_a),
    .mem_createdump(cd_a), .mem_data_out(mdo_a)
  );
  mem_stall_ctrl #(.LATENCY(0), .ALIGN_CHECK(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_wr(rw_b), .req_addr(ra_b), .req_wdata(rwd_b),
    .req_dump(rd_b), .stall(stall_b), .done(done_b), .rdata(rdata_b), .err(err_b),
    .mem_addr(maddr_b), .mem_data_in(mdin_b), .mem_enable(en_b), .mem_wr(mwr_b),
    .mem_createdump(cd_b), .mem_data_out(mdo_b)
  );

  typedef struct {bit is_err; logic [15:0] rd; int at;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int en_cnt = 0, wr_cnt = 0, dump_cnt = 0;
  int n, w0, e0, d0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(logic v, logic w, logic [15:0] a, logic [15:0] d, logic dm);
    rv = v; rw = w; ra = a; rwd = d; rd = dm;
  endtask

  task automatic monitor;
    exp_t e;
    forever begin
      @(negedge clk);
      if (en_a) en_cnt++;
      if (en_a && mwr_a) wr_cnt++;
      if (cd_a) dump_cnt++;
      total++;
      if ((en_a && cd_a) || (mwr_a && !en_a)) begin
        bad++;
        $display("FAIL mem_excl: en=%b wr=%b dump=%b want at most enable(+wr) or dump alone", en_a, mwr_a, cd_a);
      end
      if (done_a || err_a) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: done=%b err=%b cyc=%0d want no response", done_a, err_a, cyc);
        end else begin
          e = q.pop_front();
          chk("sb_err", err_a, e.is_err);
          chk("sb_done", done_a, !e.is_err);
          chk("sb_cycle", cyc, e.at);
          chk("sb_rdata", rdata_a, e.rd);
        end
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    rv_b = 0; rw_b = 0; ra_b = 0; rwd_b = 0; rd_b = 0;
    bd_we = 1; bd_addr_a = 8'h10; bd_data_a = 16'hBEEF; bd_addr_b = 8'h02; bd_data_b = 16'hA5A5;
    fork monitor(); join_none
    tick;
    bd_we = 0;
    @(negedge clk);
    chk("rst_stall", stall_a, 0); chk("rst_done", done_a, 0); chk("rst_err", err_a, 0);
    chk("rst_rdata", rdata_a, 0); chk("rst_addr", maddr_a, 0); chk("rst_din", mdin_a, 0);
    chk("rst_en", en_a, 0); chk("rst_wr", mwr_a, 0); chk("rst_dump", cd_a, 0); chk("rst_stall_b", stall_b, 0);
    tick;
    rst_n = 1;
    tick;
    // load 0x0010: stall for cycles 0..4, access in cycle 4, done in cycle 5
    drive(1, 0, 16'h0010, 0, 0);
    n = cyc;
    q.push_back('{1'b0, 16'hBEEF, n + 5});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ld_stall", stall_a, i < 5);
      chk("ld_en", en_a, i == 4);
      if (i == 4) chk("ld_addr", maddr_a, 16'h0010);
      tick;
      if (i == 0) drive(0, 0, 0, 0, 0);
    end
    // store 0x1234 @0x0020, then load it back in the done cycle
    w0 = wr_cnt;
    drive(1, 1, 16'h0020, 16'h1234, 0);
    n = cyc;
    q.push_back('{1'b0, 16'hBEEF, n + 5});
    tick;
    drive(0, 0, 0, 0, 0);
    repeat (4) tick;
    drive(1, 0, 16'h0020, 0, 0);
    q.push_back('{1'b0, 16'h1234, n + 10});
    @(negedge clk);
    chk("b2b_stall", stall_a, 1);
    chk("b2b_done", done_a, 1);
    tick;
    drive(0, 0, 0, 0, 0);
    repeat (5) tick;
    chk("st_writes", wr_cnt - w0, 1);
    chk("st_mem", mem_a[8'h20], 16'h1234);
    // misaligned load: err next cycle, no access, no stall
    e0 = en_cnt;
    drive(1, 0, 16'h0003, 0, 0);
    n = cyc;
    q.push_back('{1'b1, 16'h1234, n + 1});
    @(negedge clk);
    chk("mis_stall0", stall_a, 0);
    tick;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mis_stall1", stall_a, 0);
    repeat (3) tick;
    chk("mis_no_en", en_cnt - e0, 0);
    chk("mis_rdata", rdata_a, 16'h1234);
    // dump alone: one createdump cycle
    d0 = dump_cnt;
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("dmp_stall0", stall_a, 1);
    chk("dmp_cd0", cd_a, 0);
    tick;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("dmp_cd1", cd_a, 1);
    chk("dmp_stall1", stall_a, 1);
    chk("dmp_en1", en_a, 0);
    tick;
    @(negedge clk);
    chk("dmp_cd2", cd_a, 0);
    chk("dmp_stall2", stall_a, 0);
    tick;
    chk("dmp_count", dump_cnt - d0, 1);
    // valid and dump together: access wins
    e0 = en_cnt;
    drive(1, 0, 16'h0010, 0, 1);
    n = cyc;
    q.push_back('{1'b0, 16'hBEEF, n + 5});
    tick;
    drive(0, 0, 0, 0, 0);
    repeat (6) tick;
    chk("vd_access", en_cnt - e0, 1);
    chk("vd_no_dump", dump_cnt - d0, 1);
    // reset while a store waits
    w0 = wr_cnt;
    e0 = en_cnt;
    drive(1, 1, 16'h0030, 16'h5555, 0);
    tick;
    drive(0, 0, 0, 0, 0);
    tick;
    rst_n = 0;
    #1;
    chk("mr_stall", stall_a, 0); chk("mr_done", done_a, 0); chk("mr_err", err_a, 0);
    chk("mr_en", en_a, 0); chk("mr_wr", mwr_a, 0); chk("mr_cd", cd_a, 0);
    chk("mr_rdata", rdata_a, 0); chk("mr_addr", maddr_a, 0); chk("mr_din", mdin_a, 0);
    tick;
    tick;
    rst_n = 1;
    repeat (6) tick;
    chk("mr_no_write", wr_cnt - w0, 0);
    chk("mr_no_en", en_cnt - e0, 0);
    @(negedge clk);
    chk("mr_idle", stall_a, 0);
    tick;
    // LATENCY=0 instance: access in cycle 1, done in cycle 2
    rv_b = 1; ra_b = 16'h0002;
    @(negedge clk);
    chk("l0_stall0", stall_b, 1);
    chk("l0_en0", en_b, 0);
    tick;
    rv_b = 0;
    @(negedge clk);
    chk("l0_stall1", stall_b, 1);
    chk("l0_en1", en_b, 1);
    tick;
    @(negedge clk);
    chk("l0_stall2", stall_b, 0);
    chk("l0_done2", done_b, 1);
    chk("l0_rdata", rdata_b, 16'hA5A5);
    tick;
    @(negedge clk);
    chk("l0_done3", done_b, 0);
    repeat (3) tick;
    chk("sb_pending", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
